ctrl_unit_fsm: RTL

Multicycle control FSM that drives the datapath select lines and write enables, including the 2-bit ALU source-B selector and the 1-bit source-A selector. It is the producer side of the srcB select interface. It decodes opcode/funct from the instruction register and sequences the FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK steps. Memory waits are counted internally.

---
 rtl/ctrl_pkg.sv | 61 ++++++
 rtl/ctrl_unit_fsm.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: state enum, opcode/funct
// constants, datapath select codes and ALU operation codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        RST       = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        EXEC_R    = 4'd3,
        R_WB      = 4'd4,
        MEM_ADDR  = 4'd5,
        MEM_READ  = 4'd6,
        MEM_WB    = 4'd7,
        MEM_WRITE = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        ADDI_EX   = 4'd11,
        ADDI_WB   = 4'd12,
        BAD       = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_XOR = 6'h26;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_4       = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [2:0] ALU_NOP = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b110;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // ALU_NOP doubles as the "unsupported funct" marker since every legal op is nonzero.
    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_XOR:  return ALU_XOR;
            default: return ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_unit_fsm.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback and
// decodes datapath selects and write enables from the current state.
module ctrl_unit_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_wr,
    output logic       ir_wr,
    output logic       mdr_wr,
    output logic       a_wr,
    output logic       b_wr,
    output logic       alu_out_wr,
    output logic       reg_wr,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       srcA_selector,
    output logic [1:0] srcB_selector,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       error,
    output logic [3:0] state_dbg
);

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_t     state;
    logic [2:0] cnt;
    logic       mem_done;
    logic [2:0] r_alu;

    assign mem_done = (cnt == WAIT_LAST);
    assign r_alu    = funct_alu(funct);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RST;
            cnt   <= 3'd0;
        end else begin
            case (state)
                RST: state <= FETCH;
                FETCH, MEM_READ: begin
                    if (mem_done) begin
                        cnt   <= 3'd0;
                        state <= (state == FETCH) ? DECODE : MEM_WB;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                DECODE: begin
                    case (opcode)
                        OP_RTYPE:      state <= EXEC_R;
                        OP_LW, OP_SW:  state <= MEM_ADDR;
                        OP_BEQ, OP_BNE: state <= BRANCH;
                        OP_J:          state <= JUMP;
                        OP_ADDI:       state <= ADDI_EX;
                        default:       state <= BAD;
                    endcase
                end
                EXEC_R:   state <= (r_alu != ALU_NOP) ? R_WB : BAD;
                MEM_ADDR: state <= (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
                ADDI_EX:  state <= ADDI_WB;
                R_WB, MEM_WB, MEM_WRITE, BRANCH, JUMP, ADDI_WB: state <= FETCH;
                BAD:      state <= BAD;
                default:  state <= RST;
            endcase
        end
    end

    // Output decode is purely combinational so async reset drops every enable at once.
    always_comb begin
        pc_write      = 1'b0;
        iord          = 1'b0;
        mem_wr        = 1'b0;
        ir_wr         = 1'b0;
        mdr_wr        = 1'b0;
        a_wr          = 1'b0;
        b_wr          = 1'b0;
        alu_out_wr    = 1'b0;
        reg_wr        = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        srcA_selector = 1'b0;
        srcB_selector = SRCB_B;
        alu_op        = ALU_NOP;
        pc_source     = PC_ALU;
        error         = 1'b0;
        case (state)
            FETCH: begin
                srcB_selector = SRCB_4;
                alu_op        = ALU_ADD;
                ir_wr         = mem_done;
                pc_write      = mem_done;
            end
            DECODE: begin
                srcB_selector = SRCB_IMM_SL2;
                alu_op        = ALU_ADD;
                alu_out_wr    = 1'b1;
                a_wr          = 1'b1;
                b_wr          = 1'b1;
            end
            EXEC_R: begin
                srcA_selector = 1'b1;
                alu_op        = r_alu;
                alu_out_wr    = (r_alu != ALU_NOP);
            end
            R_WB: begin
                reg_wr  = 1'b1;
                reg_dst = 1'b1;
            end
            MEM_ADDR, ADDI_EX: begin
                srcA_selector = 1'b1;
                srcB_selector = SRCB_IMM;
                alu_op        = ALU_ADD;
                alu_out_wr    = 1'b1;
            end
            MEM_READ: begin
                iord   = 1'b1;
                mdr_wr = mem_done;
            end
            MEM_WB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                iord   = 1'b1;
                mem_wr = 1'b1;
            end
            BRANCH: begin
                srcA_selector = 1'b1;
                alu_op        = ALU_SUB;
                pc_source     = PC_ALUOUT;
                pc_write      = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
            end
            JUMP: begin
                pc_source = PC_JUMP;
                pc_write  = 1'b1;
            end
            ADDI_WB: reg_wr = 1'b1;
            BAD:     error  = 1'b1;
            default: ;
        endcase
    end

    assign state_dbg = state;

endmodule
